oursring_req_arb: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one ring station request/response port among `N_REQ` local requesters. It carries one outstanding `sd_info_t` transaction (typ/addr/data, 106 bits) at a time: it grants a requester, drives the request onto the ring, waits for the matching response, and returns that response to the owning requester. It sits between the core-side debug/CSR masters and the ring station.

---
 rtl/oursring_req_arb.sv | 136 +++++++++++++
 tb/tb_oursring_req_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/oursring_req_arb.sv
// Round-robin arbiter sharing one ring station port among N_REQ requesters.
// sd_info_t = {typ[1:0], addr[39:0], data[63:0]}; ST_ERR = 2'd3. Option: OURSRING_ARB_TIMEOUT_EN.
module oursring_req_arb #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][105:0]        req_info,
    output logic [N_REQ-1:0]               rsp_valid,
    input  logic [N_REQ-1:0]               rsp_ready,
    output logic [105:0]                   rsp_info,
    output logic                           ring_req_valid,
    input  logic                           ring_req_ready,
    output logic [105:0]                   ring_req_info,
    input  logic                           ring_rsp_valid,
    output logic                           ring_rsp_ready,
    input  logic [105:0]                   ring_rsp_info,
    output logic                           busy,
    output logic [$clog2(N_REQ)-1:0]       owner,
    output logic                           stale_drop,
    output logic                           timeout_pulse
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [1:0] ST_ERR = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ_OUT, WAIT_RSP, RSP_OUT} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_owner;
    logic [105:0]    r_txn_q;
    logic [105:0]    r_rsp_q;
    logic            r_stale;
    logic            w_hit;
    logic [IW-1:0]   w_gnt_idx;
    logic [N_REQ-1:0] w_one;

`ifdef OURSRING_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_tmo_pulse;
`endif

    assign w_one = {{(N_REQ-1){1'b0}}, 1'b1};

    // Scan downward so the nearest index after rr_ptr is the last one written.
    always_comb begin
        w_hit     = 1'b0;
        w_gnt_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_valid[IW'((int'(r_rr_ptr) + i) % N_REQ)]) begin
                w_hit     = 1'b1;
                w_gnt_idx = IW'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign req_ready      = (r_state == IDLE && w_hit) ? (w_one << w_gnt_idx) : '0;
    assign rsp_valid      = (r_state == RSP_OUT) ? (w_one << r_owner) : '0;
    assign rsp_info       = r_rsp_q;
    assign ring_req_valid = (r_state == REQ_OUT);
    assign ring_req_info  = r_txn_q;
    assign ring_rsp_ready = (r_state != RSP_OUT);
    assign busy           = (r_state != IDLE);
    assign owner          = r_owner;
    assign stale_drop     = r_stale;

`ifdef OURSRING_ARB_TIMEOUT_EN
    assign timeout_pulse  = r_tmo_pulse;
`else
    assign timeout_pulse  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rr_ptr    <= IW'(N_REQ - 1);
            r_owner     <= '0;
            r_txn_q     <= '0;
            r_rsp_q     <= '0;
            r_stale     <= 1'b0;
`ifdef OURSRING_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_tmo_pulse <= 1'b0;
`endif
        end else begin
            r_stale <= ring_rsp_valid && (r_state == IDLE || r_state == REQ_OUT);
`ifdef OURSRING_ARB_TIMEOUT_EN
            r_tmo_pulse <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_txn_q <= req_info[w_gnt_idx];
                        r_owner <= w_gnt_idx;
                        r_state <= REQ_OUT;
                    end
                end
                REQ_OUT: begin
                    if (ring_req_ready) begin
                        r_state   <= WAIT_RSP;
`ifdef OURSRING_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                WAIT_RSP: begin
                    if (ring_rsp_valid) begin
                        r_rsp_q <= ring_rsp_info;
                        r_state <= RSP_OUT;
                    end
`ifdef OURSRING_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_rsp_q     <= {ST_ERR, r_txn_q[103:64], 64'h0};
                        r_tmo_pulse <= 1'b1;
                        r_state     <= RSP_OUT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                RSP_OUT: begin
                    if (rsp_ready[r_owner]) begin
                        r_rr_ptr <= r_owner;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oursring_req_arb.sv
// Scoreboard bench for oursring_req_arb: bench acts as requesters and ring.
// Timeout cases run only when OURSRING_ARB_TIMEOUT_EN is defined.
module tb_oursring_req_arb;
    localparam int N = 4;
    localparam logic [1:0] ST_RD  = 2'd0;
    localparam logic [1:0] ST_WR  = 2'd1;
    localparam logic [1:0] ST_RSP = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    logic               clk = 1'b0;
    logic               rstn;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][105:0] req_info;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [105:0]       rsp_info;
    logic               ring_req_valid;
    logic               ring_req_ready;
    logic [105:0]       ring_req_info;
    logic               ring_rsp_valid;
    logic               ring_rsp_ready;
    logic [105:0]       ring_rsp_info;
    logic               busy;
    logic [1:0]         owner;
    logic               stale_drop;
    logic               timeout_pulse;

    int n_chk = 0;
    int n_err = 0;
    int m_rr;
    int n_ring_hs = 0;
    int n_rsp_hs = 0;
    logic [105:0] sb_q[$];

    oursring_req_arb #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_info(req_info),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_info(rsp_info),
        .ring_req_valid(ring_req_valid), .ring_req_ready(ring_req_ready),
        .ring_req_info(ring_req_info),
        .ring_rsp_valid(ring_rsp_valid), .ring_rsp_ready(ring_rsp_ready),
        .ring_rsp_info(ring_rsp_info),
        .busy(busy), .owner(owner),
        .stale_drop(stale_drop), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ring_req_valid && ring_req_ready) n_ring_hs++;
        if ((rsp_valid & rsp_ready) != '0) n_rsp_hs++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [105:0] mk(input logic [1:0] t, input logic [39:0] a,
                                        input logic [63:0] d);
        return {t, a, d};
    endfunction

    function automatic int pick(input logic [N-1:0] m);
        for (int i = 1; i <= N; i++)
            if (m[(m_rr + i) % N]) return (m_rr + i) % N;
        return 0;
    endfunction

    // Called on a negedge with the DUT in IDLE; returns on the negedge after
    // the requester handshake.
    task automatic do_txn(input logic [N-1:0] vmask, input int rw, input int rwait,
                          input int rdw, input bit tmo, input logic [63:0] rdata);
        int g, cyc, rh0, sh0;
        logic [105:0] t, ex;
        cyc = 0;
        rh0 = n_ring_hs;
        sh0 = n_rsp_hs;
        g = pick(vmask);
        req_valid = vmask;
        #1;
        chk("req_ready", req_ready, 128'(1) << g);
        t = req_info[g];
        @(negedge clk); cyc++;
        chk("ring_req_valid", ring_req_valid, 1);
        chk("ring_req_info", ring_req_info, t);
        chk("owner", owner, g);
        chk("busy", busy, 1);
        req_info[g][63:0] = req_info[g][63:0] + 64'd1;
        for (int i = 0; i < rw; i++) begin
            @(negedge clk); cyc++;
            chk("ring_req_hold", {ring_req_valid, ring_req_info}, {1'b1, t});
        end
        ring_req_ready = 1'b1;
        @(negedge clk); cyc++;
        ring_req_ready = 1'b0;
        chk("ring_req_drop", ring_req_valid, 0);
        for (int j = 0; j < rwait; j++) begin
            chk("wait_rsp", {rsp_valid, ring_rsp_ready}, 5'b00001);
            @(negedge clk); cyc++;
        end
        if (!tmo) begin
            ring_rsp_info = mk(ST_RSP, t[103:64], rdata);
            ring_rsp_valid = 1'b1;
            sb_q.push_back(mk(ST_RSP, t[103:64], rdata));
            @(negedge clk); cyc++;
            ring_rsp_valid = 1'b0;
            ring_rsp_info = '0;
        end else begin
            sb_q.push_back(mk(ST_ERR, t[103:64], 64'h0));
        end
        chk("timeout_pulse", timeout_pulse, tmo);
        chk("rsp_valid", rsp_valid, 128'(1) << g);
        ex = sb_q.pop_front();
        chk("rsp_info", rsp_info, ex);
        chk("ring_rsp_ready_off", ring_rsp_ready, 0);
        for (int i = 0; i < rdw; i++) begin
            @(negedge clk); cyc++;
            chk("rsp_hold", {rsp_valid, rsp_info}, {4'(1 << g), ex});
        end
        rsp_ready = 4'(1 << g);
        @(negedge clk); cyc++;
        rsp_ready = '0;
        chk("rsp_done", {busy, rsp_valid}, 0);
        chk("cycles", cyc, (tmo ? 3 : 4) + rw + rwait + rdw);
        chk("ring_hs", n_ring_hs - rh0, 1);
        chk("rsp_hs", n_rsp_hs - sh0, 1);
        m_rr = g;
        req_valid = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"},
            {busy, owner, ring_req_valid, ring_rsp_ready, rsp_valid, req_ready,
             stale_drop, timeout_pulse},
            {1'b0, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0});
        chk({tag, "_rsp_info"}, rsp_info, 0);
        chk({tag, "_ring_req_info"}, ring_req_info, 0);
    endtask

    task automatic stale_test(input string tag);
        ring_rsp_info = mk(ST_RSP, 40'hAB, 64'h55);
        ring_rsp_valid = 1'b1;
        @(negedge clk);
        ring_rsp_valid = 1'b0;
        chk({tag, "_pulse"}, {stale_drop, rsp_valid, busy}, {1'b1, 4'd0, 1'b0});
        @(negedge clk);
        chk({tag, "_end"}, {stale_drop, rsp_valid}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        ring_req_ready = 1'b0;
        ring_rsp_valid = 1'b0;
        ring_rsp_info = '0;
        for (int i = 0; i < N; i++)
            req_info[i] = mk(ST_RD, 40'h20_0000_0000 | 40'(i << 8), 64'(i) << 32);
        m_rr = N - 1;
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // fairness: all hold valid, expect 0,1,2,3,0
        for (int k = 0; k < 5; k++)
            do_txn(4'hF, 0, 0, 0, 0, 64'($urandom));
        chk("fair_last", m_rr, 0);

        req_info[0] = mk(ST_WR, 40'h10_0000_0040, 64'hDEAD_BEEF);
        do_txn(4'b0001, 0, 3, 0, 0, 64'h0);

        for (int k = 0; k < 3; k++)
            do_txn(4'b1010, k, k, 0, 0, 64'($urandom));

        do_txn(4'b0100, 5, 2, 3, 0, 64'h1234_5678_9ABC_DEF0);

        stale_test("stale");
        do_txn(4'b1001, 0, 1, 1, 0, 64'hCAFE);

`ifdef OURSRING_ARB_TIMEOUT_EN
        req_info[1] = mk(ST_RD, 40'h0_0000_1000, 64'h0);
        do_txn(4'b0010, 0, 8, 0, 1, 64'h0);
        stale_test("late");
        req_info[1] = mk(ST_RD, 40'h0_0000_1000, 64'h0);
        do_txn(4'b0010, 0, 7, 0, 0, 64'h0BAD_F00D);
`else
        do_txn(4'b0010, 0, 20, 0, 0, 64'h0BAD_F00D);
`endif

        // reset while waiting for the ring response
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        ring_req_ready = 1'b1;
        @(negedge clk);
        ring_req_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk);
        rstn = 1'b1;
        m_rr = N - 1;
        @(negedge clk);
        do_txn(4'hF, 0, 0, 0, 0, 64'h77);
        chk("post_rst_owner", m_rr, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
